// File: rtl/pipe_pkg.sv
// Shared encodings for the MEM/WB boundary: write-back source, load size
// and the link-address offset.
package pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_DMEM = 2'd1,
    WB_LINK = 2'd2,
    WB_AUX  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B  = 2'd0,
    LD_H  = 2'd1,
    LD_W  = 2'd2,
    LD_W3 = 2'd3
  } ld_size_e;

  // Return address skips the branch delay slot.
  localparam int LINK_OFS = 8;

endpackage

// File: rtl/load_align.sv
// Little-endian byte/half-word extract with zero/sign extension, plus
// detection of half/word loads that straddle their natural alignment.
module load_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] result,
  output logic              misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  ld_size_e    sz;

  assign sz     = ld_size_e'(size);
  assign byte_v = data[{off, 3'b000} +: 8];
  assign half_v = data[{off[1], 4'b0000} +: 16];

  always_comb begin
    result   = data;
    misalign = 1'b0;
    case (sz)
      LD_B: begin
        result = {{(DATA_W-8){is_signed & byte_v[7]}}, byte_v};
      end
      LD_H: begin
        result   = {{(DATA_W-16){is_signed & half_v[15]}}, half_v};
        misalign = off[0];
      end
      default: begin
        // Size 3 behaves as a full word.
        result   = data;
        misalign = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register with write-back source select, sub-word load
// alignment, misaligned-write suppression and a retired-write counter.
module pipe_mem_wb
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd_waddr,
  input  logic              in_rd_wena,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_dmem_data,
  input  logic [DATA_W-1:0] in_link_pc,
  input  logic [DATA_W-1:0] in_aux_data,
  output logic [REG_AW-1:0] out_rd_waddr,
  output logic              out_rd_wena,
  output logic [DATA_W-1:0] out_rd_wdata,
  output logic              out_misalign,
  output logic [CNT_W-1:0]  out_retired
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd_waddr;
    logic              rd_wena;
    logic [1:0]        wb_sel;
    logic [1:0]        ld_size;
    logic              ld_signed;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] dmem_data;
    logic [DATA_W-1:0] link_pc;
    logic [DATA_W-1:0] aux_data;
  } mw_t;

  mw_t               mw_d, mw_q;
  logic [CNT_W-1:0]  ret_d, ret_q;
  logic [DATA_W-1:0] ld_data;
  logic              ld_misalign;
  logic              is_dmem;

  always_comb begin
    mw_d = mw_q;
    if (flush) begin
      mw_d = '0;
    end else if (!stall) begin
      mw_d = '{valid:      in_valid,
               rd_waddr:   in_rd_waddr,
               rd_wena:    in_rd_wena,
               wb_sel:     in_wb_sel,
               ld_size:    in_ld_size,
               ld_signed:  in_ld_signed,
               alu_result: in_alu_result,
               dmem_data:  in_dmem_data,
               link_pc:    in_link_pc,
               aux_data:   in_aux_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mw_q <= '0;
    end else begin
      mw_q <= mw_d;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .data      (mw_q.dmem_data),
    .off       (mw_q.alu_result[1:0]),
    .size      (mw_q.ld_size),
    .is_signed (mw_q.ld_signed),
    .result    (ld_data),
    .misalign  (ld_misalign)
  );

  assign is_dmem = (wb_sel_e'(mw_q.wb_sel) == WB_DMEM);

  always_comb begin
    out_rd_wdata = mw_q.alu_result;
    case (wb_sel_e'(mw_q.wb_sel))
      WB_ALU:  out_rd_wdata = mw_q.alu_result;
      WB_DMEM: out_rd_wdata = ld_data;
      WB_LINK: out_rd_wdata = mw_q.link_pc + DATA_W'(LINK_OFS);
      WB_AUX:  out_rd_wdata = mw_q.aux_data;
      default: out_rd_wdata = mw_q.alu_result;
    endcase
  end

  assign out_rd_waddr = mw_q.rd_waddr;
  assign out_misalign = mw_q.valid & is_dmem & ld_misalign;
  assign out_rd_wena  = mw_q.valid & mw_q.rd_wena & (mw_q.rd_waddr != '0) & ~out_misalign;

  // A held instruction with wena set is counted on every cycle it is held.
  assign ret_d = ret_q + CNT_W'(out_rd_wena);

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign out_retired = ret_q;

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Scoreboard bench for pipe_mem_wb: directed vectors push expected outputs,
// a negedge monitor pops and compares; a CNT_W=4 twin checks counter wrap.
module tb_pipe_mem_wb;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_rd_wena, in_ld_signed;
  logic [4:0]  in_rd_waddr;
  logic [1:0]  in_wb_sel, in_ld_size;
  logic [31:0] in_alu_result, in_dmem_data, in_link_pc, in_aux_data;

  logic [4:0]  out_rd_waddr, out4_rd_waddr;
  logic        out_rd_wena, out4_rd_wena;
  logic [31:0] out_rd_wdata, out4_rd_wdata;
  logic        out_misalign, out4_misalign;
  logic [31:0] out_retired;
  logic [3:0]  out4_retired;

  always #5 clk = ~clk;

  pipe_mem_wb #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd_waddr(in_rd_waddr), .in_rd_wena(in_rd_wena),
    .in_wb_sel(in_wb_sel), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_alu_result(in_alu_result), .in_dmem_data(in_dmem_data),
    .in_link_pc(in_link_pc), .in_aux_data(in_aux_data),
    .out_rd_waddr(out_rd_waddr), .out_rd_wena(out_rd_wena),
    .out_rd_wdata(out_rd_wdata), .out_misalign(out_misalign),
    .out_retired(out_retired)
  );

  pipe_mem_wb #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd_waddr(in_rd_waddr), .in_rd_wena(in_rd_wena),
    .in_wb_sel(in_wb_sel), .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
    .in_alu_result(in_alu_result), .in_dmem_data(in_dmem_data),
    .in_link_pc(in_link_pc), .in_aux_data(in_aux_data),
    .out_rd_waddr(out4_rd_waddr), .out_rd_wena(out4_rd_wena),
    .out_rd_wdata(out4_rd_wdata), .out_misalign(out4_misalign),
    .out_retired(out4_retired)
  );

  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic        wena;
    logic [31:0] wdata;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = '0;
  logic        last_wena = 1'b0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are stable here, half a cycle after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.name, "waddr",   {27'b0, out_rd_waddr}, {27'b0, e.waddr});
        cmp(e.name, "wena",    {31'b0, out_rd_wena},  {31'b0, e.wena});
        cmp(e.name, "wdata",   out_rd_wdata,          e.wdata);
        cmp(e.name, "mis",     {31'b0, out_misalign}, {31'b0, e.mis});
        cmp(e.name, "retired", out_retired,           e.cnt);
        cmp(e.name, "wena4",   {31'b0, out4_rd_wena}, {31'b0, e.wena});
        cmp(e.name, "ret4",    {28'b0, out4_retired}, {28'b0, e.cnt[3:0]});
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [1:0] sz, input logic sg,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc, input logic [31:0] ax);
    in_valid = v; in_rd_waddr = rd; in_rd_wena = we; in_wb_sel = sel;
    in_ld_size = sz; in_ld_signed = sg; in_alu_result = alu;
    in_dmem_data = dm; in_link_pc = pc; in_aux_data = ax;
  endtask

  // Advance one edge and queue the hand-computed outputs expected after it.
  task automatic tick(input string nm, input logic [4:0] ea, input logic ew,
                      input logic [31:0] ed, input logic em);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst) exp_cnt = '0;
    else     exp_cnt = exp_cnt + {31'b0, last_wena};
    last_wena = ew;
    e.name = nm; e.waddr = ea; e.wena = ew; e.wdata = ed; e.mis = em; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  localparam logic [31:0] DM = 32'h8091A2B3;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, WB_ALU, LD_W, 0, 0, 0, 0, 0);
    repeat (2) tick("reset", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (10) tick("idle", 0, 0, 0, 0);

    drive(1, 2, 1, WB_DMEM, LD_B, 1, 32'h1001, DM, 0, 0);
    tick("lb_s_off1", 2, 1, 32'hFFFFFFA2, 0);
    drive(1, 2, 1, WB_DMEM, LD_B, 0, 32'h1001, DM, 0, 0);
    tick("lbu_off1", 2, 1, 32'h000000A2, 0);
    drive(1, 2, 1, WB_DMEM, LD_B, 0, 32'h1003, DM, 0, 0);
    tick("lbu_off3", 2, 1, 32'h00000080, 0);
    drive(1, 2, 1, WB_DMEM, LD_B, 1, 32'h1000, DM, 0, 0);
    tick("lb_s_off0", 2, 1, 32'hFFFFFFB3, 0);
    drive(1, 2, 1, WB_DMEM, LD_H, 1, 32'h1002, DM, 0, 0);
    tick("lh_s_off2", 2, 1, 32'hFFFF8091, 0);
    drive(1, 2, 1, WB_DMEM, LD_H, 0, 32'h1000, DM, 0, 0);
    tick("lhu_off0", 2, 1, 32'h0000A2B3, 0);
    drive(1, 5, 1, WB_DMEM, LD_H, 0, 32'h1003, DM, 0, 0);
    tick("lh_mis", 5, 0, 32'h00008091, 1);
    drive(1, 6, 1, WB_DMEM, LD_W, 0, 32'h1000, DM, 0, 0);
    tick("lw_ok", 6, 1, DM, 0);
    drive(1, 6, 1, WB_DMEM, LD_W, 0, 32'h1002, DM, 0, 0);
    tick("lw_mis", 6, 0, DM, 1);
    drive(1, 6, 1, WB_DMEM, 2'd3, 0, 32'h1000, DM, 0, 0);
    tick("lsz3_word", 6, 1, DM, 0);
    drive(1, 6, 1, WB_ALU, LD_W, 0, 32'h1002, DM, 0, 0);
    tick("alu_odd_no_mis", 6, 1, 32'h00001002, 0);

    drive(1, 31, 1, WB_LINK, LD_W, 0, 0, 0, 32'h00400010, 0);
    tick("link", 31, 1, 32'h00400018, 0);
    drive(1, 31, 1, WB_LINK, LD_W, 0, 0, 0, 32'hFFFFFFFC, 0);
    tick("link_wrap", 31, 1, 32'h00000004, 0);
    drive(1, 0, 1, WB_ALU, LD_W, 0, 32'h1234, 0, 0, 0);
    tick("alu_r0", 0, 0, 32'h00001234, 0);
    drive(1, 31, 1, WB_AUX, LD_W, 0, 0, 0, 0, 32'hDEAD);
    tick("aux_r31", 31, 1, 32'h0000DEAD, 0);
    drive(0, 9, 1, WB_AUX, LD_W, 0, 0, 0, 0, 32'hBEEF);
    tick("invalid", 9, 0, 32'h0000BEEF, 0);
    drive(1, 9, 0, WB_AUX, LD_W, 0, 0, 0, 0, 32'hBEEF);
    tick("no_wena", 9, 0, 32'h0000BEEF, 0);

    drive(1, 3, 1, WB_ALU, LD_W, 0, 32'h11, 0, 0, 0);
    tick("stall_cap", 3, 1, 32'h11, 0);
    stall = 1'b1;
    drive(1, 4, 1, WB_ALU, LD_W, 0, 32'h22, 0, 0, 0);
    repeat (3) tick("stall_hold", 3, 1, 32'h11, 0);
    flush = 1'b1;
    tick("flush_stall", 0, 0, 0, 0);
    flush = 1'b0; stall = 1'b0;
    tick("release", 4, 1, 32'h22, 0);

    drive(1, 7, 1, WB_ALU, LD_W, 0, 32'h77, 0, 0, 0);
    tick("pre_rst", 7, 1, 32'h77, 0);
    rst = 1'b1; flush = 1'b1; stall = 1'b1;
    tick("rst_mid", 0, 0, 0, 0);
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
    drive(0, 0, 0, WB_ALU, LD_W, 0, 0, 0, 0, 0);
    tick("post_rst", 0, 0, 0, 0);

    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 1, WB_ALU, LD_W, 0, 32'(i), 0, 0, 0);
      tick("wrap_wr", 1, 1, 32'(i), 0);
    end
    drive(0, 0, 0, WB_ALU, LD_W, 0, 0, 0, 0, 0);
    tick("wrap_end", 0, 0, 0, 0);
    tick("wrap_idle", 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
